// File: rtl/register_file_16bit_32size.sv
// -----------------------------------------------------------------------------
// register_file_16bit_32size
//
// General-purpose register storage for the 16-bit datapath: 32 registers of
// 16 bits, one synchronous write port and two combinational read ports. The
// read ports feed ALU operands; ALU results come back through the write port.
// A flattened copy of the whole file is exported for debug and monitoring.
//
// Ports
//   clk             system clock, writes commit on its rising edge
//   rst             asynchronous active-high reset, clears every register
//   mode            1 = write on this edge, 0 (or unknown) = no write
//   WriteAddress    destination register index
//   WriteValue      data to store
//   ReadAddress1    read port 1 index
//   ReadAddress2    read port 2 index
//   ReadValue1      contents of register ReadAddress1 (combinational)
//   ReadValue2      contents of register ReadAddress2 (combinational)
//   outRegisterFile all registers, register i at bits [16*i+15 : 16*i]
//
// Register 0 is an ordinary register; nothing is hardwired to zero.
// There is no write-to-read bypass: a read of the register being written
// returns the old value until the clock edge commits the write.
// -----------------------------------------------------------------------------
module register_file_16bit_32size #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [ADDR_WIDTH-1:0]         WriteAddress,
    input  logic [DATA_WIDTH-1:0]         WriteValue,
    input  logic [ADDR_WIDTH-1:0]         ReadAddress1,
    input  logic [ADDR_WIDTH-1:0]         ReadAddress2,
    output logic [DATA_WIDTH-1:0]         ReadValue1,
    output logic [DATA_WIDTH-1:0]         ReadValue2,
    output logic [DATA_WIDTH*DEPTH-1:0]   outRegisterFile
);

    // Storage array; index range matches the full address space.
    logic [DATA_WIDTH-1:0] registers [DEPTH];

    // Write port. Reset has priority over any write on the same edge, so an
    // edge with rst=1 and mode=1 leaves everything at zero. The explicit
    // compare against 1'b1 means an unknown mode never commits a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (mode == 1'b1) begin
            registers[WriteAddress] <= WriteValue;
        end
    end

    // Read ports: pure combinational lookup of current storage.
    assign ReadValue1 = registers[ReadAddress1];
    assign ReadValue2 = registers[ReadAddress2];

    // Debug flattening, register i occupies slice [DATA_WIDTH*i +: DATA_WIDTH].
    always_comb begin
        outRegisterFile = '0;
        for (int i = 0; i < DEPTH; i++) begin
            outRegisterFile[DATA_WIDTH*i +: DATA_WIDTH] = registers[i];
        end
    end

endmodule

// File: tb/tb_register_file_16bit_32size.sv
module tb_register_file_16bit_32size;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    // ------------------------------------------------------------------
    // clock / reset block
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] WriteAddress = '0;
    logic [DW-1:0] WriteValue = '0;
    logic [AW-1:0] ReadAddress1 = '0;
    logic [AW-1:0] ReadAddress2 = '0;
    logic [DW-1:0] ReadValue1;
    logic [DW-1:0] ReadValue2;
    logic [DW*DEPTH-1:0] outRegisterFile;

    always #5 clk = ~clk;

    register_file_16bit_32size #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .WriteAddress(WriteAddress),
        .WriteValue(WriteValue),
        .ReadAddress1(ReadAddress1),
        .ReadAddress2(ReadAddress2),
        .ReadValue1(ReadValue1),
        .ReadValue2(ReadValue2),
        .outRegisterFile(outRegisterFile)
    );

    // ------------------------------------------------------------------
    // scoreboard state
    // ------------------------------------------------------------------
    int n_compared   = 0;
    int n_mismatched = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_v;
    logic [DW*DEPTH-1:0] exp_flat;

    function automatic logic [DW*DEPTH-1:0] flat_of_model();
        logic [DW*DEPTH-1:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) f[DW*i +: DW] = model[i];
        return f;
    endfunction

    // ------------------------------------------------------------------
    // driver tasks
    // ------------------------------------------------------------------
    // Called just after a rising edge; commits on the next one.
    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mode = 1'b1;
        WriteAddress = a;
        WriteValue = v;
        @(posedge clk);
        #1;
        mode = 1'b0;
        if (!rst) model[a] = v;
    endtask

    // ------------------------------------------------------------------
    // scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL reset_rv1: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue2 !== exp_v) begin
            n_mismatched++;
            $display("FAIL reset_rv2: got %h want %h", ReadValue2, exp_v);
        end
        n_compared++;
        if (outRegisterFile !== '0) begin
            n_mismatched++;
            $display("FAIL reset_flat: got %h want 0", outRegisterFile);
        end
        // write attempt while reset held
        mode = 1'b1; WriteAddress = 5'd3; WriteValue = 16'hFFFF; ReadAddress1 = 5'd3;
        @(posedge clk);
        #1;
        exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL reset_write_ignored: got %h want %h", ReadValue1, exp_v);
        end
        n_compared++;
        if (outRegisterFile !== '0) begin
            n_mismatched++;
            $display("FAIL reset_write_flat: got %h want 0", outRegisterFile);
        end
        mode = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_dual_read();
        drive_write(5'd0, 16'h1232);
        drive_write(5'd1, 16'h1263);
        ReadAddress1 = 5'd0; ReadAddress2 = 5'd1;
        #1;
        exp_q.push_back(16'h1232);
        exp_q.push_back(16'h1263);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL dual_read_rv1: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue2 !== exp_v) begin
            n_mismatched++;
            $display("FAIL dual_read_rv2: got %h want %h", ReadValue2, exp_v);
        end
    endtask

    task automatic test_writeback_sum();
        logic [DW-1:0] a, b;
        a = 16'h1232; b = 16'h1263;
        drive_write(5'd2, a + b);
        ReadAddress1 = 5'd2;
        #1;
        exp_q.push_back(16'h2495);
        exp_q.push_back(16'h2495);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL sum_rv1: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (outRegisterFile[47:32] !== exp_v) begin
            n_mismatched++;
            $display("FAIL sum_flat: got %h want %h", outRegisterFile[47:32], exp_v);
        end
    endtask

    task automatic test_no_bypass();
        ReadAddress1 = 5'd5;
        mode = 1'b1; WriteAddress = 5'd5; WriteValue = 16'hABCD;
        #1;
        exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL no_bypass_before: got %h want %h", ReadValue1, exp_v);
        end
        @(posedge clk);
        #1;
        model[5] = 16'hABCD;
        exp_q.push_back(16'hABCD);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL no_bypass_after: got %h want %h", ReadValue1, exp_v);
        end
        // read mode edge must not write
        mode = 1'b0; WriteValue = 16'h5555;
        @(posedge clk);
        #1;
        exp_q.push_back(16'hABCD);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL read_mode_hold: got %h want %h", ReadValue1, exp_v);
        end
        // unknown mode must not write either
        mode = 1'bx; WriteValue = 16'h1111;
        @(posedge clk);
        #1;
        mode = 1'b0;
        exp_q.push_back(16'hABCD);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL x_mode_hold: got %h want %h", ReadValue1, exp_v);
        end
    endtask

    task automatic test_boundaries();
        drive_write(5'd31, 16'hDEAD);
        drive_write(5'd0, 16'hBEEF);
        ReadAddress1 = 5'd31; ReadAddress2 = 5'd31;
        #1;
        exp_q.push_back(16'hDEAD);
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hDEAD);
        exp_q.push_back(16'hDEAD);
        exp_v = exp_q.pop_front(); n_compared++;
        if (outRegisterFile[511:496] !== exp_v) begin
            n_mismatched++;
            $display("FAIL bound_flat_top: got %h want %h", outRegisterFile[511:496], exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (outRegisterFile[15:0] !== exp_v) begin
            n_mismatched++;
            $display("FAIL bound_flat_bottom: got %h want %h", outRegisterFile[15:0], exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL bound_rv1_31: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue2 !== exp_v) begin
            n_mismatched++;
            $display("FAIL bound_rv2_31: got %h want %h", ReadValue2, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        drive_write(5'd7, 16'h0001);
        drive_write(5'd7, 16'h0002);
        drive_write(5'd8, 16'h0003);
        ReadAddress1 = 5'd7; ReadAddress2 = 5'd8;
        #1;
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL b2b_last_wins: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue2 !== exp_v) begin
            n_mismatched++;
            $display("FAIL b2b_next_addr: got %h want %h", ReadValue2, exp_v);
        end
    endtask

    task automatic test_random();
        logic m;
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        for (int n = 0; n < 60; n++) begin
            m = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, DEPTH-1));
            v = DW'($urandom_range(0, 16'hFFFF));
            mode = m; WriteAddress = a; WriteValue = v;
            @(posedge clk);
            #1;
            mode = 1'b0;
            if (m) model[a] = v;
            ReadAddress1 = AW'($urandom_range(0, DEPTH-1));
            ReadAddress2 = AW'($urandom_range(0, DEPTH-1));
            #1;
            exp_q.push_back(model[ReadAddress1]);
            exp_q.push_back(model[ReadAddress2]);
            exp_v = exp_q.pop_front(); n_compared++;
            if (ReadValue1 !== exp_v) begin
                n_mismatched++;
                $display("FAIL rand_rv1[%0d]: addr %0d got %h want %h", n, ReadAddress1, ReadValue1, exp_v);
            end
            exp_v = exp_q.pop_front(); n_compared++;
            if (ReadValue2 !== exp_v) begin
                n_mismatched++;
                $display("FAIL rand_rv2[%0d]: addr %0d got %h want %h", n, ReadAddress2, ReadValue2, exp_v);
            end
        end
        exp_flat = flat_of_model();
        n_compared++;
        if (outRegisterFile !== exp_flat) begin
            n_mismatched++;
            $display("FAIL rand_flat: got %h want %h", outRegisterFile, exp_flat);
        end
    endtask

    task automatic test_async_reset();
        ReadAddress1 = 5'd31; ReadAddress2 = 5'd2;
        #2;
        rst = 1'b1;
        #1;
        // still mid-cycle: no clock edge since rst rose
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL async_rst_rv1: got %h want %h", ReadValue1, exp_v);
        end
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue2 !== exp_v) begin
            n_mismatched++;
            $display("FAIL async_rst_rv2: got %h want %h", ReadValue2, exp_v);
        end
        n_compared++;
        if (outRegisterFile !== '0) begin
            n_mismatched++;
            $display("FAIL async_rst_flat: got %h want 0", outRegisterFile);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // first edge after release writes
        drive_write(5'd9, 16'h3C3C);
        ReadAddress1 = 5'd9;
        #1;
        exp_q.push_back(16'h3C3C);
        exp_v = exp_q.pop_front(); n_compared++;
        if (ReadValue1 !== exp_v) begin
            n_mismatched++;
            $display("FAIL post_rst_write: got %h want %h", ReadValue1, exp_v);
        end
        exp_flat = flat_of_model();
        n_compared++;
        if (outRegisterFile !== exp_flat) begin
            n_mismatched++;
            $display("FAIL post_rst_flat: got %h want %h", outRegisterFile, exp_flat);
        end
    endtask

    // ------------------------------------------------------------------
    // sequence and final report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_write_dual_read();
        test_writeback_sum();
        test_no_bypass();
        test_boundaries();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
